// File: rtl/multi_channel_iq_acc.sv
// Multi-channel I/Q demodulation accumulator: per-channel sin/cos products summed over
// a programmable number of reference periods, delivered one result at a time over a valid/ready port.
module multi_channel_iq_acc #(
    parameter int CHANNELS       = 4,
    parameter int ADC_DATA_WIDTH = 12,
    parameter int REF_DATA_WIDTH = 13,
    parameter int MUL_ACC_WIDTH  = 32,
    parameter int PERIODS_WIDTH  = 8
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 CE,
    input  logic signed [ADC_DATA_WIDTH-1:0]     ADC_VALUE,
    input  logic [CHANNELS*REF_DATA_WIDTH-1:0]   REF_SIN,
    input  logic [CHANNELS*REF_DATA_WIDTH-1:0]   REF_COS,
    input  logic [CHANNELS-1:0]                  PERIOD_START,
    input  logic [CHANNELS-1:0]                  CH_ENABLE,
    input  logic [PERIODS_WIDTH-1:0]             PERIODS_PER_RESULT,
    output logic                                 RESULT_VALID,
    input  logic                                 RESULT_READY,
    output logic [2:0]                           RESULT_CHANNEL,
    output logic signed [MUL_ACC_WIDTH-1:0]      RESULT_SIN,
    output logic signed [MUL_ACC_WIDTH-1:0]      RESULT_COS,
    output logic [15:0]                          RESULT_SAMPLES,
    output logic                                 RESULT_OVERFLOW,
    output logic [CHANNELS-1:0]                  DROPPED
);
    localparam int PROD_W = ADC_DATA_WIDTH + REF_DATA_WIDTH;
    localparam int SUM_W  = ((PROD_W > MUL_ACC_WIDTH) ? PROD_W : MUL_ACC_WIDTH) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-MUL_ACC_WIDTH+1){1'b0}}, {(MUL_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-MUL_ACC_WIDTH+1){1'b1}}, {(MUL_ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ST_IDLE, ST_ACCUM} ch_state_t;

    // Returns {clamped, saturated sum}.
    function automatic logic [MUL_ACC_WIDTH:0] sat_add(input logic signed [MUL_ACC_WIDTH-1:0] a,
                                                        input logic signed [PROD_W-1:0] p);
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(p);
        if (s > SAT_MAX)
            return {1'b1, SAT_MAX[MUL_ACC_WIDTH-1:0]};
        else if (s < SAT_MIN)
            return {1'b1, SAT_MIN[MUL_ACC_WIDTH-1:0]};
        else
            return {1'b0, s[MUL_ACC_WIDTH-1:0]};
    endfunction

    logic [CHANNELS-1:0]               hold_full;
    logic [CHANNELS-1:0]               release_vec;
    logic [CHANNELS-1:0]               cand;
    logic [CHANNELS*MUL_ACC_WIDTH-1:0] hold_sin_flat;
    logic [CHANNELS*MUL_ACC_WIDTH-1:0] hold_cos_flat;
    logic [CHANNELS*16-1:0]            hold_samples_flat;
    logic [CHANNELS-1:0]               hold_ovf_vec;

    logic                              result_valid_reg;
    logic [2:0]                        result_channel_reg;
    logic signed [MUL_ACC_WIDTH-1:0]   result_sin_reg;
    logic signed [MUL_ACC_WIDTH-1:0]   result_cos_reg;
    logic [15:0]                       result_samples_reg;
    logic                              result_ovf_reg;
    logic [2:0]                        rr_ptr_reg;
    logic [2:0]                        rr_ptr_next;

    logic                              out_free;
    logic                              grant_found;
    logic [2:0]                        grant_idx;
    logic [MUL_ACC_WIDTH-1:0]          sel_sin;
    logic [MUL_ACC_WIDTH-1:0]          sel_cos;
    logic [15:0]                       sel_samples;
    logic                              sel_ovf;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic signed [PROD_W-1:0]        s1_sin_reg, s1_cos_reg;
            logic                            s1_start_reg;
            ch_state_t                       state_reg, state_next;
            logic signed [MUL_ACC_WIDTH-1:0] acc_sin_reg, acc_sin_next, acc_cos_reg, acc_cos_next;
            logic [15:0]                     samples_reg, samples_next;
            logic                            ovf_reg, ovf_next;
            logic [PERIODS_WIDTH-1:0]        period_cnt_reg, period_cnt_next, setting_reg, setting_next;
            logic                            hold_full_reg, hold_full_next, hold_ovf_reg, hold_ovf_next;
            logic signed [MUL_ACC_WIDTH-1:0] hold_sin_reg, hold_sin_next, hold_cos_reg, hold_cos_next;
            logic [15:0]                     hold_samples_reg, hold_samples_next;
            logic                            dropped_reg, dropped_next;
            logic [MUL_ACC_WIDTH:0]          sa_sin, sa_cos;
            logic                            restart, accumulate, close;

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    s1_sin_reg   <= '0;
                    s1_cos_reg   <= '0;
                    s1_start_reg <= 1'b0;
                end else if (CE) begin
                    s1_sin_reg   <= PROD_W'(ADC_VALUE) * PROD_W'($signed(REF_SIN[gi*REF_DATA_WIDTH +: REF_DATA_WIDTH]));
                    s1_cos_reg   <= PROD_W'(ADC_VALUE) * PROD_W'($signed(REF_COS[gi*REF_DATA_WIDTH +: REF_DATA_WIDTH]));
                    s1_start_reg <= PERIOD_START[gi];
                end
            end

            always_comb begin
                state_next        = state_reg;
                acc_sin_next      = acc_sin_reg;
                acc_cos_next      = acc_cos_reg;
                samples_next      = samples_reg;
                ovf_next          = ovf_reg;
                period_cnt_next   = period_cnt_reg;
                setting_next      = setting_reg;
                hold_full_next    = hold_full_reg;
                hold_sin_next     = hold_sin_reg;
                hold_cos_next     = hold_cos_reg;
                hold_samples_next = hold_samples_reg;
                hold_ovf_next     = hold_ovf_reg;
                dropped_next      = dropped_reg;
                restart           = 1'b0;
                accumulate        = 1'b0;
                close             = 1'b0;

                if (!CH_ENABLE[gi]) begin
                    state_next      = ST_IDLE;
                    acc_sin_next    = '0;
                    acc_cos_next    = '0;
                    samples_next    = '0;
                    ovf_next        = 1'b0;
                    period_cnt_next = '0;
                end else if (CE) begin
                    case (state_reg)
                        ST_IDLE:  restart = s1_start_reg;
                        ST_ACCUM: begin
                            accumulate = 1'b1;
                            if (s1_start_reg) begin
                                // The strobe beginning period setting+1 closes the window and opens the next.
                                if (period_cnt_reg >= setting_reg) begin
                                    close      = 1'b1;
                                    restart    = 1'b1;
                                    accumulate = 1'b0;
                                end else begin
                                    period_cnt_next = period_cnt_reg + PERIODS_WIDTH'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end

                sa_sin = sat_add(restart ? '0 : acc_sin_reg, s1_sin_reg);
                sa_cos = sat_add(restart ? '0 : acc_cos_reg, s1_cos_reg);

                if (restart) begin
                    state_next      = ST_ACCUM;
                    setting_next    = (PERIODS_PER_RESULT == '0) ? PERIODS_WIDTH'(1) : PERIODS_PER_RESULT;
                    period_cnt_next = PERIODS_WIDTH'(1);
                    acc_sin_next    = sa_sin[MUL_ACC_WIDTH-1:0];
                    acc_cos_next    = sa_cos[MUL_ACC_WIDTH-1:0];
                    samples_next    = 16'd1;
                    ovf_next        = sa_sin[MUL_ACC_WIDTH] | sa_cos[MUL_ACC_WIDTH];
                end else if (accumulate) begin
                    acc_sin_next = sa_sin[MUL_ACC_WIDTH-1:0];
                    acc_cos_next = sa_cos[MUL_ACC_WIDTH-1:0];
                    samples_next = (samples_reg == 16'hFFFF) ? samples_reg : samples_reg + 16'd1;
                    ovf_next     = ovf_reg | sa_sin[MUL_ACC_WIDTH] | sa_cos[MUL_ACC_WIDTH];
                end

                // The hold stays full while its result is presented; it frees on the handshake.
                if (release_vec[gi])
                    hold_full_next = 1'b0;
                if (close) begin
                    if (hold_full_reg && !release_vec[gi]) begin
                        dropped_next = 1'b1;
                    end else begin
                        hold_full_next    = 1'b1;
                        hold_sin_next     = acc_sin_reg;
                        hold_cos_next     = acc_cos_reg;
                        hold_samples_next = samples_reg;
                        hold_ovf_next     = ovf_reg;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    state_reg        <= ST_IDLE;
                    acc_sin_reg      <= '0;
                    acc_cos_reg      <= '0;
                    samples_reg      <= '0;
                    ovf_reg          <= 1'b0;
                    period_cnt_reg   <= '0;
                    setting_reg      <= '0;
                    hold_full_reg    <= 1'b0;
                    hold_sin_reg     <= '0;
                    hold_cos_reg     <= '0;
                    hold_samples_reg <= '0;
                    hold_ovf_reg     <= 1'b0;
                    dropped_reg      <= 1'b0;
                end else begin
                    state_reg        <= state_next;
                    acc_sin_reg      <= acc_sin_next;
                    acc_cos_reg      <= acc_cos_next;
                    samples_reg      <= samples_next;
                    ovf_reg          <= ovf_next;
                    period_cnt_reg   <= period_cnt_next;
                    setting_reg      <= setting_next;
                    hold_full_reg    <= hold_full_next;
                    hold_sin_reg     <= hold_sin_next;
                    hold_cos_reg     <= hold_cos_next;
                    hold_samples_reg <= hold_samples_next;
                    hold_ovf_reg     <= hold_ovf_next;
                    dropped_reg      <= dropped_next;
                end
            end

            assign release_vec[gi] = result_valid_reg && RESULT_READY && (result_channel_reg == 3'(gi));
            assign hold_full[gi]   = hold_full_reg;
            assign hold_ovf_vec[gi] = hold_ovf_reg;
            assign hold_sin_flat[gi*MUL_ACC_WIDTH +: MUL_ACC_WIDTH] = hold_sin_reg;
            assign hold_cos_flat[gi*MUL_ACC_WIDTH +: MUL_ACC_WIDTH] = hold_cos_reg;
            assign hold_samples_flat[gi*16 +: 16] = hold_samples_reg;
            assign DROPPED[gi]     = dropped_reg;
        end
    endgenerate

    assign out_free = !result_valid_reg || RESULT_READY;
    assign cand     = hold_full & ~release_vec;

    // Round-robin: lowest candidate at or above the pointer, else lowest overall.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        sel_sin     = '0;
        sel_cos     = '0;
        sel_samples = '0;
        sel_ovf     = 1'b0;
        if (out_free) begin
            for (int j = CHANNELS - 1; j >= 0; j--) begin
                if (cand[j] && (j >= int'(rr_ptr_reg))) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(j);
                end
            end
            if (!grant_found) begin
                for (int j = CHANNELS - 1; j >= 0; j--) begin
                    if (cand[j]) begin
                        grant_found = 1'b1;
                        grant_idx   = 3'(j);
                    end
                end
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant_idx == 3'(j)) begin
                sel_sin     = hold_sin_flat[j*MUL_ACC_WIDTH +: MUL_ACC_WIDTH];
                sel_cos     = hold_cos_flat[j*MUL_ACC_WIDTH +: MUL_ACC_WIDTH];
                sel_samples = hold_samples_flat[j*16 +: 16];
                sel_ovf     = hold_ovf_vec[j];
            end
        end
        rr_ptr_next = (grant_idx == 3'(CHANNELS - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            result_valid_reg   <= 1'b0;
            result_channel_reg <= 3'd0;
            result_sin_reg     <= '0;
            result_cos_reg     <= '0;
            result_samples_reg <= '0;
            result_ovf_reg     <= 1'b0;
            rr_ptr_reg         <= 3'd0;
        end else if (grant_found) begin
            result_valid_reg   <= 1'b1;
            result_channel_reg <= grant_idx;
            result_sin_reg     <= sel_sin;
            result_cos_reg     <= sel_cos;
            result_samples_reg <= sel_samples;
            result_ovf_reg     <= sel_ovf;
            rr_ptr_reg         <= rr_ptr_next;
        end else if (RESULT_READY) begin
            result_valid_reg   <= 1'b0;
        end
    end

    assign RESULT_VALID    = result_valid_reg;
    assign RESULT_CHANNEL  = result_channel_reg;
    assign RESULT_SIN      = result_sin_reg;
    assign RESULT_COS      = result_cos_reg;
    assign RESULT_SAMPLES  = result_samples_reg;
    assign RESULT_OVERFLOW = result_ovf_reg;
endmodule

// File: tb/tb_multi_channel_iq_acc.sv
// Directed bench for multi_channel_iq_acc: table of window experiments plus
// hand-written drop, reset, channel-disable and free/refill sequences.
module tb_multi_channel_iq_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic signed [11:0] adc = '0;
    logic [25:0] ref_sin = '0;
    logic [25:0] ref_cos = '0;
    logic [1:0]  period_start = '0;
    logic [1:0]  ch_enable = 2'b11;
    logic [7:0]  ppr = 8'd1;
    logic        ready = 1'b1;
    logic        use16 = 1'b0;

    logic               r_valid, q_valid;
    logic [2:0]         r_ch, q_ch;
    logic signed [31:0] r_sin, r_cos;
    logic signed [15:0] q_sin, q_cos;
    logic [15:0]        r_samples, q_samples;
    logic               r_ovf, q_ovf;
    logic [1:0]         r_dropped, q_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_channel_iq_acc #(.CHANNELS(2)) dut (
        .CLK(clk), .RESET(rst_n), .CE(ce), .ADC_VALUE(adc),
        .REF_SIN(ref_sin), .REF_COS(ref_cos), .PERIOD_START(period_start),
        .CH_ENABLE(ch_enable), .PERIODS_PER_RESULT(ppr),
        .RESULT_VALID(r_valid), .RESULT_READY(ready), .RESULT_CHANNEL(r_ch),
        .RESULT_SIN(r_sin), .RESULT_COS(r_cos), .RESULT_SAMPLES(r_samples),
        .RESULT_OVERFLOW(r_ovf), .DROPPED(r_dropped)
    );

    multi_channel_iq_acc #(.CHANNELS(2), .MUL_ACC_WIDTH(16)) dut16 (
        .CLK(clk), .RESET(rst_n), .CE(ce), .ADC_VALUE(adc),
        .REF_SIN(ref_sin), .REF_COS(ref_cos), .PERIOD_START(period_start),
        .CH_ENABLE(ch_enable), .PERIODS_PER_RESULT(ppr),
        .RESULT_VALID(q_valid), .RESULT_READY(ready), .RESULT_CHANNEL(q_ch),
        .RESULT_SIN(q_sin), .RESULT_COS(q_cos), .RESULT_SAMPLES(q_samples),
        .RESULT_OVERFLOW(q_ovf), .DROPPED(q_dropped)
    );

    logic               s_valid, s_ovf;
    logic [2:0]         s_ch;
    logic signed [63:0] s_sin, s_cos;
    logic [15:0]        s_samples;
    assign s_valid   = use16 ? q_valid : r_valid;
    assign s_ch      = use16 ? q_ch : r_ch;
    assign s_sin     = use16 ? 64'(q_sin) : 64'(r_sin);
    assign s_cos     = use16 ? 64'(q_cos) : 64'(r_cos);
    assign s_samples = use16 ? q_samples : r_samples;
    assign s_ovf     = use16 ? q_ovf : r_ovf;

    typedef struct {
        bit     use16;
        int     setting;
        int     interval;
        int     adc;
        int     rsin;
        int     rcos;
        longint exp_sin;
        longint exp_cos;
        int     exp_samples;
        int     exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] mask);
        period_start = mask;
        @(posedge clk);
        #1;
        period_start = 2'b00;
    endtask

    task automatic quiet(input int n);
        repeat (n) apply(2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet(2);
        rst_n = 1'b1;
    endtask

    task automatic set_refs(input int a, input int rs, input int rc);
        logic signed [12:0] s13, c13;
        s13 = 13'(rs);
        c13 = 13'(rc);
        adc = 12'(a);
        ref_sin = {s13, s13};
        ref_cos = {c13, c13};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{0, 1, 40, 100, 10, -5, 40000, -20000, 40, 0};
        vecs[1] = '{0, 3, 20, 100, 10, -5, 60000, -30000, 60, 0};
        vecs[2] = '{0, 0, 20, 100, 10, -5, 20000, -10000, 20, 0};
        vecs[3] = '{0, 2, 5, -2048, -4096, 4095, 83886080, -83865600, 10, 0};
        vecs[4] = '{1, 1, 10, 2047, 4095, -4095, 32767, -32768, 10, 1};
        vecs[5] = '{1, 1, 10, 3, 7, -2, 210, -60, 10, 0};

        foreach (vecs[i]) begin
            vec_t v;
            int   eff;
            v = vecs[i];
            use16 = v.use16;
            ppr = 8'(v.setting);
            set_refs(v.adc, v.rsin, v.rcos);
            ch_enable = 2'b11;
            ready = 1'b1;
            do_reset();
            eff = (v.setting == 0) ? 1 : v.setting;
            for (int b = 0; b < eff; b++) begin
                apply(2'b11);
                quiet(v.interval - 1);
            end
            apply(2'b11);
            quiet(1);
            check($sformatf("v%0d valid_early", i), s_valid, 0);
            quiet(1);
            check($sformatf("v%0d valid", i), s_valid, 1);
            check($sformatf("v%0d ch0", i), s_ch, 0);
            check($sformatf("v%0d sin", i), s_sin, v.exp_sin);
            check($sformatf("v%0d cos", i), s_cos, v.exp_cos);
            check($sformatf("v%0d samples", i), s_samples, v.exp_samples);
            check($sformatf("v%0d ovf", i), s_ovf, v.exp_ovf);
            quiet(1);
            check($sformatf("v%0d ch1", i), s_ch, 1);
            check($sformatf("v%0d ch1_sin", i), s_sin, v.exp_sin);
            $display("vector %0d: setting=%0d interval=%0d checked", i, v.setting, v.interval);
        end
        use16 = 1'b0;

        // Back-pressure across two closes, then reset while a result is pending.
        ppr = 8'd1;
        set_refs(100, 10, -5);
        ch_enable = 2'b01;
        ready = 1'b0;
        do_reset();
        apply(2'b01); quiet(9);
        apply(2'b01); quiet(2);
        check("hold valid1", r_valid, 1);
        check("hold sin1", r_sin, 10000);
        check("hold samples1", r_samples, 10);
        quiet(7);
        apply(2'b01); quiet(3);
        check("hold valid2", r_valid, 1);
        check("hold sin2", r_sin, 10000);
        check("dropped set", r_dropped, 2'b01);
        ready = 1'b1; quiet(1); ready = 1'b0;
        check("after transfer valid", r_valid, 0);
        $display("drop sequence: first result held, DROPPED=%b", r_dropped);
        quiet(5);
        apply(2'b01); quiet(2);
        check("third window valid", r_valid, 1);
        check("third window sin", r_sin, 10000);
        quiet(2);
        rst_n = 1'b0; quiet(1); rst_n = 1'b1;
        check("rst valid", r_valid, 0);
        check("rst channel", r_ch, 0);
        check("rst sin", r_sin, 0);
        check("rst cos", r_cos, 0);
        check("rst samples", r_samples, 0);
        check("rst ovf", r_ovf, 0);
        check("rst dropped", r_dropped, 0);
        quiet(4);
        apply(2'b01); quiet(2);
        check("post-rst no stale", r_valid, 0);
        quiet(7);
        apply(2'b01); quiet(2);
        check("post-rst valid", r_valid, 1);
        check("post-rst sin", r_sin, 10000);
        check("post-rst samples", r_samples, 10);
        $display("reset sequence: fresh window samples=%0d", r_samples);

        // Channel disabled mid-window discards the partial window.
        ready = 1'b1;
        do_reset();
        apply(2'b01); quiet(4);
        ch_enable = 2'b00; quiet(1); ch_enable = 2'b01;
        quiet(4);
        apply(2'b01); quiet(2);
        check("disable no stale", r_valid, 0);
        quiet(7);
        apply(2'b01); quiet(2);
        check("disable valid", r_valid, 1);
        check("disable samples", r_samples, 10);
        check("disable sin", r_sin, 10000);
        $display("disable sequence: samples=%0d sin=%0d", r_samples, r_sin);

        // Hold freed by a transfer in the same cycle a new window closes.
        ready = 1'b0;
        do_reset();
        apply(2'b01); quiet(9);
        adc = 12'sd50;
        apply(2'b01); quiet(2);
        check("refill first sin", r_sin, 10000);
        quiet(7);
        apply(2'b01);
        ready = 1'b1; quiet(1); ready = 1'b0;
        quiet(1);
        check("refill valid", r_valid, 1);
        check("refill sin", r_sin, 5000);
        check("refill no drop", r_dropped, 0);
        $display("refill sequence: sin=%0d dropped=%b", r_sin, r_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
